mult_seq_ctrl: RTL and testbench

- FSM controller that sequences the shift-add multiplier datapath: the PH accumulator, the PL multiplier/product-low register, the multiplicand register, the adder and the carry flip-flop.
- Issues load, add and shift strobes, counts N bit-iterations, and reports completion over a start/done handshake.
- Sits between the lab top-level control (switches/buttons or a test FSM) and the datapath registers.
- Contains no datapath arithmetic.

---
 rtl/mult_pkg.sv | 5 +
 rtl/mult_seq_ctrl_iter_cnt.sv | 25 ++
 rtl/mult_seq_ctrl.sv | 69 ++++++
 tb/tb_mult_seq_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared state encoding and default operand width for the shift-add multiplier.
package mult_pkg;
   localparam int MULT_N = 4;
   typedef enum logic [2:0] {IDLE, LOAD, ADD, SHIFT, DONE} state_t;
endpackage

// File: rtl/mult_seq_ctrl_iter_cnt.sv
// iter_cnt: loadable down-counter of remaining add/shift iterations with zero/last flags.
module iter_cnt #(
   parameter int N  = 4,
   parameter int CW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          i_clr,
   input  logic          i_ld,
   input  logic          i_dec,
   output logic [CW-1:0] o_cnt,
   output logic          o_zero,
   output logic          o_last
);
   logic [CW-1:0] r_cnt;
   // The zero guard keeps a stray decrement from wrapping the count.
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_ld) r_cnt <= CW'(N);
      else if (i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   assign o_cnt  = r_cnt;
   assign o_zero = r_cnt == '0;
   assign o_last = r_cnt == CW'(1);
endmodule

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: FSM sequencing load/add/shift strobes of a shift-add multiplier datapath
// over a start/done handshake.
module mult_seq_ctrl
   import mult_pkg::*;
#(
   parameter int N  = MULT_N,
   parameter int CW = $clog2(N) + 1
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          start,
   input  logic          abort,
   input  logic          lsb,
   output logic          load,
   output logic          add,
   output logic          sft,
   output logic          carry_sel,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] cnt
);
   state_t r_state, w_next;
   logic   r_add_seen;
   logic   w_zero, w_last;

   iter_cnt #(.N(N), .CW(CW)) u_cnt (
      .clk   (clk),
      .clr_n (clr_n),
      .i_clr (abort),
      .i_ld  (r_state == LOAD),
      .i_dec (r_state == SHIFT),
      .o_cnt (cnt),
      .o_zero(w_zero),
      .o_last(w_last)
   );

   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) r_state <= IDLE;
      else r_state <= w_next;

   // Remembers whether this iteration added, so the shift pulls in the adder carry.
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) r_add_seen <= 1'b0;
      else if (abort || r_state == LOAD) r_add_seen <= 1'b0;
      else if (r_state == ADD) r_add_seen <= lsb;

   always_comb begin
      w_next    = r_state;
      load      = 1'b0;
      add       = 1'b0;
      sft       = 1'b0;
      carry_sel = 1'b0;
      busy      = r_state != IDLE;
      done      = 1'b0;
      case (r_state)
         IDLE:  w_next = start ? LOAD : IDLE;
         LOAD:  begin load = 1'b1; w_next = ADD; end
         ADD:   begin add = lsb; w_next = SHIFT; end
         SHIFT: begin
            sft       = 1'b1;
            carry_sel = r_add_seen;
            w_next    = (w_last || w_zero) ? DONE : ADD;
         end
         DONE:  begin done = 1'b1; w_next = IDLE; end
         default: w_next = IDLE;
      endcase
      if (abort) w_next = IDLE;
   end
endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: directed scenario bench for the multiplier sequencer (N=4, done 10 cycles after start).
module tb_mult_seq_ctrl;
   logic       clk = 1'b0, clr_n = 1'b0, start = 1'b0, abort = 1'b0, lsb = 1'b0;
   logic       load, add, sft, carry_sel, busy, done;
   logic [2:0] cnt;
   int         checks = 0, errors = 0;

   mult_seq_ctrl #(.N(4)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .abort(abort), .lsb(lsb),
      .load(load), .add(add), .sft(sft), .carry_sel(carry_sel),
      .busy(busy), .done(done), .cnt(cnt)
   );

   always #5 clk = ~clk;

   wire [8:0] obs = {load, add, sft, carry_sel, busy, done, cnt};

   // Expected {load,add,sft,carry_sel,busy,done,cnt} in cycle c after the start edge; pat[i] is lsb of iteration i.
   function automatic logic [8:0] exp_vec(input int c, input logic [3:0] pat);
      logic       ld, ad, sf, cs, bz, dn;
      logic [2:0] ct;
      ld = c == 1;
      ad = (c >= 2 && c <= 8 && c % 2 == 0) ? pat[(c - 2) / 2] : 1'b0;
      sf = c >= 3 && c <= 9 && c % 2 == 1;
      cs = sf ? pat[(c - 3) / 2] : 1'b0;
      bz = c >= 1 && c <= 10;
      dn = c == 10;
      ct = (c >= 2 && c <= 9) ? 3'(4 - (c - 2) / 2) : 3'd0;
      return {ld, ad, sf, cs, bz, dn, ct};
   endfunction

   // lsb carries the pattern bit in ADD cycles and is forced high elsewhere.
   function automatic logic lsb_for(input int c, input logic [3:0] pat);
      return (c >= 2 && c <= 8 && c % 2 == 0) ? pat[(c - 2) / 2] : 1'b1;
   endfunction

   task automatic test_reset();
      clr_n = 1'b0; start = 1'b1; lsb = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== 9'd0) begin errors++; $display("FAIL reset_hold obs=%b exp=%b", obs, 9'd0); end
      clr_n = 1'b1; start = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== 9'd0) begin errors++; $display("FAIL reset_release obs=%b exp=%b", obs, 9'd0); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; lsb = 1'b0;
      #1;
      checks++;
      if (load !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL reset_first_load load=%b busy=%b exp=1 1", load, busy); end
      repeat (12) @(negedge clk);
   endtask

   task automatic test_seq(input string name, input logic [3:0] pat);
      int nsft = 0;
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         start = 1'b0;
         lsb = lsb_for(c, pat);
         #1;
         nsft += sft;
         checks++;
         if (obs !== exp_vec(c, pat)) begin errors++; $display("FAIL %s cyc%0d obs=%b exp=%b", name, c, obs, exp_vec(c, pat)); end
      end
      checks++;
      if (nsft != 4) begin errors++; $display("FAIL %s sft_count got=%0d exp=4", name, nsft); end
   endtask

   task automatic test_nominal();
      test_seq("nominal", 4'b1011);
   endtask

   task automatic test_zero();
      test_seq("zero", 4'b0000);
   endtask

   task automatic test_abort();
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
         lsb = lsb_for(c, 4'b1111);
      end
      #1;
      checks++;
      if (obs !== exp_vec(7, 4'b1111)) begin errors++; $display("FAIL abort_pre obs=%b exp=%b", obs, exp_vec(7, 4'b1111)); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      #1;
      checks++;
      if (obs !== 9'd0) begin errors++; $display("FAIL abort_idle obs=%b exp=%b", obs, 9'd0); end
      for (int c = 9; c <= 12; c++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc%0d done=%b busy=%b exp=0 0", c, done, busy); end
      end
      test_seq("after_abort", 4'b0110);
   endtask

   task automatic test_back_to_back();
      lsb = 1'b0;
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({load, done, busy} !== {c % 11 == 1, c % 11 == 10, c % 11 != 0}) begin
            errors++;
            $display("FAIL held_start cyc%0d load/done/busy=%b exp=%b", c, {load, done, busy}, {c % 11 == 1, c % 11 == 10, c % 11 != 0});
         end
      end
      start = 1'b0;
      repeat (5) @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL held_start_stop busy=%b exp=0", busy); end
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         start = c == 5;
         #1;
         checks++;
         if ({load, done, busy} !== {c == 1, c == 10, c <= 10}) begin
            errors++;
            $display("FAIL busy_start cyc%0d load/done/busy=%b exp=%b", c, {load, done, busy}, {c == 1, c == 10, c <= 10});
         end
      end
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; lsb = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (add !== 1'b1) begin errors++; $display("FAIL mid_add_pre add=%b exp=1", add); end
      #1 clr_n = 1'b0;
      #1;
      checks++;
      if (obs !== 9'd0) begin errors++; $display("FAIL mid_reset_async obs=%b exp=%b", obs, 9'd0); end
      repeat (2) @(negedge clk);
      clr_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (obs !== 9'd0) begin errors++; $display("FAIL mid_reset_idle cyc%0d obs=%b exp=%b", c, obs, 9'd0); end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_zero();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
